bram_port_arbiter: RTL and testbench

Two-requester arbiter sharing one BRAM read/write port between the host-side access path (requester 0, register/DMA bridge) and the vector compute engine (requester 1). It registers the winning command onto the BRAM port and routes the returning read data back to the issuing requester. It supports round-robin fairness, a lock for burst ownership, and a saturating contention counter. One instance sits in front of each shared BRAM.

---
 rtl/bram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester BRAM port arbiter with lock, read return routing and contention counter
module bram_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic [1:0]        i_lock,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_bram_en,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  input  logic [DATA_W-1:0] i_bram_rd_data,
  input  logic              i_cnt_clr,
  output logic [15:0]       o_conflict_cnt,
  output logic [1:0]        o_lock_owner
);

  // arbitration state: last winner, one-hot lock owner, contention counter
  logic        last_q, last_d;
  logic [1:0]  owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;

  // registered BRAM command plus the read tag that travels with it
  logic              bram_en_q, bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_wdata_q;
  logic              cmd_rd_q, cmd_id_q;

  // read-return tag pipeline, aligned with the BRAM read latency
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_id_q;

  logic [1:0] owner_eff, elig, cand, gnt;
  logic       win_id, conflict;

  // an owner that has released its lock this cycle no longer restricts arbitration
  always_comb begin
    owner_eff = owner_q & i_lock;
    elig      = (owner_eff != 2'b00) ? owner_eff : 2'b11;
    cand      = i_req & elig;
    gnt       = 2'b00;
    win_id    = 1'b0;
    if (i_reset_n) begin
      if (cand == 2'b11) begin
        win_id = ~last_q;
        gnt    = last_q ? 2'b01 : 2'b10;
      end else if (cand[0]) begin
        win_id = 1'b0;
        gnt    = 2'b01;
      end else if (cand[1]) begin
        win_id = 1'b1;
        gnt    = 2'b10;
      end
    end
  end

  // next-state for round-robin pointer, lock ownership and saturating counter
  always_comb begin
    last_d  = (gnt != 2'b00) ? win_id : last_q;
    owner_d = owner_eff;
    if ((owner_eff == 2'b00) && ((gnt & i_lock) != 2'b00)) begin
      owner_d = gnt & i_lock;
    end
    conflict = |(i_req & ~gnt);
    cnt_d    = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = 16'h0000;
    end else if (conflict && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // arbitration state registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      last_q  <= 1'b1;
      owner_q <= 2'b00;
      cnt_q   <= 16'h0000;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // capture the winning command onto the BRAM port; address/data hold when idle
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      cmd_rd_q     <= 1'b0;
      cmd_id_q     <= 1'b0;
    end else begin
      bram_en_q <= |gnt;
      bram_we_q <= (|gnt) & i_we[win_id];
      cmd_rd_q  <= (|gnt) & ~i_we[win_id];
      cmd_id_q  <= win_id;
      if (|gnt) begin
        bram_addr_q  <= win_id ? i_addr1 : i_addr0;
        bram_wdata_q <= win_id ? i_wdata1 : i_wdata0;
      end
    end
  end

  // shift read tags so each emerges when its BRAM data does
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      pipe_vld_q[0] <= cmd_rd_q;
      pipe_id_q[0]  <= cmd_id_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
    end
  end

  // route returning read data to the requester that issued it
  always_comb begin
    o_rvalid = 2'b00;
    o_rdata  = '0;
    if (pipe_vld_q[RD_LATENCY-1]) begin
      o_rvalid = pipe_id_q[RD_LATENCY-1] ? 2'b10 : 2'b01;
      o_rdata  = i_bram_rd_data;
    end
  end

  assign o_gnt          = gnt;
  assign o_bram_en      = bram_en_q;
  assign o_bram_we      = bram_we_q;
  assign o_bram_addr    = bram_addr_q;
  assign o_bram_wdata   = bram_wdata_q;
  assign o_conflict_cnt = cnt_q;
  assign o_lock_owner   = owner_eff;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed and randomized checks of bram_port_arbiter against a queue-based model
module tb_bram_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 256;
  localparam int RD_LATENCY = 2;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic              i_reset_n;
  logic [1:0]        i_req, i_we, i_lock;
  logic [ADDR_W-1:0] i_addr0, i_addr1;
  logic [DATA_W-1:0] i_wdata0, i_wdata1;
  logic [DATA_W-1:0] i_bram_rd_data;
  logic              i_cnt_clr;
  logic [1:0]        o_gnt, o_rvalid, o_lock_owner;
  logic [DATA_W-1:0] o_rdata, o_bram_wdata;
  logic              o_bram_en, o_bram_we;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [15:0]       o_conflict_cnt;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_we(i_we),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .i_lock(i_lock), .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_bram_en(o_bram_en), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
    .o_bram_wdata(o_bram_wdata), .i_bram_rd_data(i_bram_rd_data), .i_cnt_clr(i_cnt_clr),
    .o_conflict_cnt(o_conflict_cnt), .o_lock_owner(o_lock_owner)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DATA_W-1:0] preload(input int a);
    logic [DATA_W-1:0] v;
    v = {8{(32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F}};
    v[31:0] = (a == 5) ? 32'h0000_ABCD : 32'(a);
    return v;
  endfunction

  // BRAM stand-in with two cycles of read latency
  logic              load_mem = 1'b0;
  logic [DATA_W-1:0] bram_mem [512];
  logic [DATA_W-1:0] bd1, bd2;
  always @(posedge i_clk) begin
    if (load_mem) begin
      for (int i = 0; i < 512; i++) bram_mem[i] <= preload(i);
    end else if (o_bram_en && o_bram_we) begin
      bram_mem[o_bram_addr] <= o_bram_wdata;
    end
    if (o_bram_en && !o_bram_we) bd1 <= bram_mem[o_bram_addr];
    bd2 <= bd1;
  end
  assign i_bram_rd_data = bd2;

  // reference model: memory image, pending read returns, arbitration rules
  typedef struct { int due; int id; logic [DATA_W-1:0] data; } rd_t;
  rd_t               rq[$];
  logic [DATA_W-1:0] m_mem [512];
  int m_last, m_owner, m_cnt, cyc, win, eff;
  logic [1:0]        exp_gnt, exp_rvalid, exp_owner;
  logic [DATA_W-1:0] exp_rdata;
  logic [15:0]       exp_cnt;

  task automatic model_eval();
    bit c0, c1;
    @(negedge i_clk);
    eff = (m_owner >= 0 && i_lock[m_owner]) ? m_owner : -1;
    win = -1;
    if (i_reset_n) begin
      c0 = i_req[0] && (eff != 1);
      c1 = i_req[1] && (eff != 0);
      if (c0 && c1) win = 1 - m_last;
      else if (c0) win = 0;
      else if (c1) win = 1;
    end
    exp_gnt    = (win < 0) ? 2'b00 : 2'(1 << win);
    exp_owner  = (eff < 0) ? 2'b00 : 2'(1 << eff);
    exp_rvalid = 2'b00;
    exp_rdata  = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rvalid = 2'(1 << rq[0].id);
      exp_rdata  = rq[0].data;
    end
    exp_cnt = 16'(m_cnt);
  endtask

  task automatic model_commit();
    int  a;
    rd_t e;
    if (!i_reset_n) begin
      m_last = 1; m_owner = -1; m_cnt = 0;
      rq.delete();
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (win >= 0) begin
        a = (win == 0) ? int'(i_addr0) : int'(i_addr1);
        if (i_we[win]) begin
          m_mem[a] = (win == 0) ? i_wdata0 : i_wdata1;
        end else begin
          e.due = cyc + 1 + RD_LATENCY; e.id = win; e.data = m_mem[a];
          rq.push_back(e);
        end
        m_last = win;
      end
      if (eff >= 0) m_owner = eff;
      else if (win >= 0 && i_lock[win]) m_owner = win;
      else m_owner = -1;
      if (i_cnt_clr) m_cnt = 0;
      else if (((i_req & ~exp_gnt) != 2'b00) && m_cnt < 65535) m_cnt++;
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    i_req = 2'b00; i_we = 2'b00; i_lock = 2'b00; i_cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; load_mem = 1'b1;
    i_req = 2'b11; i_we = 2'b00; i_lock = 2'b11; i_cnt_clr = 1'b0;
    i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;
    model_eval(); model_commit();
    load_mem = 1'b0;
    model_eval();
    n_cmp++; if (o_gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%0h want=0", o_gnt); end
    n_cmp++; if (o_rvalid !== 2'b00) begin n_err++; $display("FAIL reset_rvalid got=%0h want=0", o_rvalid); end
    n_cmp++; if (o_rdata !== '0) begin n_err++; $display("FAIL reset_rdata got=%0h want=0", o_rdata); end
    n_cmp++; if ({o_bram_en, o_bram_we} !== 2'b00) begin n_err++; $display("FAIL reset_en_we got=%0h want=0", {o_bram_en, o_bram_we}); end
    n_cmp++; if (o_bram_addr !== '0 || o_bram_wdata !== '0) begin n_err++; $display("FAIL reset_addr_wdata got=%0h/%0h want=0", o_bram_addr, o_bram_wdata); end
    n_cmp++; if (o_conflict_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got=%0h want=0", o_conflict_cnt); end
    n_cmp++; if (o_lock_owner !== 2'b00) begin n_err++; $display("FAIL reset_owner got=%0h want=0", o_lock_owner); end
    model_commit();
    i_reset_n = 1'b1; drive_idle();
  endtask

  task automatic test_solo_read();
    i_req = 2'b01; i_we = 2'b00; i_addr0 = 9'd5;
    model_eval();
    n_cmp++; if (o_gnt !== exp_gnt || o_gnt !== 2'b01) begin n_err++; $display("FAIL solo_gnt got=%0h want=%0h", o_gnt, exp_gnt); end
    model_commit();
    drive_idle();
    for (int k = 1; k <= 4; k++) begin
      model_eval();
      if (k == 1) begin
        n_cmp++; if (o_bram_en !== 1'b1 || o_bram_we !== 1'b0 || o_bram_addr !== 9'd5) begin
          n_err++; $display("FAIL solo_cmd got en=%0b we=%0b addr=%0d want en=1 we=0 addr=5", o_bram_en, o_bram_we, o_bram_addr); end
      end
      n_cmp++; if (o_rvalid !== exp_rvalid) begin n_err++; $display("FAIL solo_rvalid cyc%0d got=%0h want=%0h", k, o_rvalid, exp_rvalid); end
      if (k == 3) begin
        n_cmp++; if (o_rvalid !== 2'b01 || o_rdata !== exp_rdata || o_rdata[15:0] !== 16'hABCD) begin
          n_err++; $display("FAIL solo_rdata got=%0h/%0h want=1/%0h", o_rvalid, o_rdata, exp_rdata); end
      end
      model_commit();
    end
  endtask

  task automatic test_tie_fairness();
    int n0, n1;
    n0 = 0; n1 = 0;
    i_cnt_clr = 1'b1;
    model_eval(); model_commit();
    i_cnt_clr = 1'b0;
    i_addr0 = 9'd16; i_addr1 = 9'd32;
    for (int k = 0; k < 8 + 4; k++) begin
      if (k < 8) begin i_req = 2'b11; i_we = 2'b00; end else drive_idle();
      model_eval();
      n_cmp++; if (o_gnt !== exp_gnt) begin n_err++; $display("FAIL tie_gnt cyc%0d got=%0h want=%0h", k, o_gnt, exp_gnt); end
      n_cmp++; if (o_rvalid !== exp_rvalid) begin n_err++; $display("FAIL tie_rvalid cyc%0d got=%0h want=%0h", k, o_rvalid, exp_rvalid); end
      if (exp_rvalid != 2'b00) begin
        n_cmp++; if (o_rdata !== exp_rdata) begin n_err++; $display("FAIL tie_rdata cyc%0d got=%0h want=%0h", k, o_rdata, exp_rdata); end
      end
      if (k == 8) begin
        n_cmp++; if (o_conflict_cnt !== 16'd8) begin n_err++; $display("FAIL tie_cnt got=%0d want=8", o_conflict_cnt); end
      end
      if (o_gnt == 2'b01) n0++;
      if (o_gnt == 2'b10) n1++;
      model_commit();
    end
    n_cmp++; if (n0 != 4 || n1 != 4) begin n_err++; $display("FAIL tie_balance got=%0d/%0d want=4/4", n0, n1); end
  endtask

  task automatic test_lock();
    i_req = 2'b10; i_we = 2'b00; i_lock = 2'b10; i_addr1 = 9'd40; i_addr0 = 9'd50;
    model_eval();
    n_cmp++; if (o_gnt !== 2'b10) begin n_err++; $display("FAIL lock_take_gnt got=%0h want=2", o_gnt); end
    model_commit();
    for (int k = 0; k < 4 + 1 + 4; k++) begin
      if (k < 4) begin i_req = 2'b11; i_lock = 2'b10; end
      else if (k == 4) begin i_req = 2'b11; i_lock = 2'b00; end
      else drive_idle();
      model_eval();
      n_cmp++; if (o_gnt !== exp_gnt) begin n_err++; $display("FAIL lock_gnt cyc%0d got=%0h want=%0h", k, o_gnt, exp_gnt); end
      n_cmp++; if (o_lock_owner !== exp_owner) begin n_err++; $display("FAIL lock_owner cyc%0d got=%0h want=%0h", k, o_lock_owner, exp_owner); end
      n_cmp++; if (o_rvalid !== exp_rvalid) begin n_err++; $display("FAIL lock_rvalid cyc%0d got=%0h want=%0h", k, o_rvalid, exp_rvalid); end
      if (k < 4) begin
        n_cmp++; if (o_gnt !== 2'b10 || o_lock_owner !== 2'b10) begin n_err++; $display("FAIL lock_hold cyc%0d got=%0h/%0h want=2/2", k, o_gnt, o_lock_owner); end
      end
      if (k == 4) begin
        n_cmp++; if (o_gnt !== 2'b01 || o_lock_owner !== 2'b00) begin n_err++; $display("FAIL lock_release got=%0h/%0h want=1/0", o_gnt, o_lock_owner); end
      end
      model_commit();
    end
  endtask

  task automatic test_write_read();
    i_req = 2'b10; i_we = 2'b10; i_addr1 = 9'd127; i_wdata1 = 256'h1234;
    model_eval();
    n_cmp++; if (o_gnt !== exp_gnt) begin n_err++; $display("FAIL wr_gnt got=%0h want=%0h", o_gnt, exp_gnt); end
    model_commit();
    i_req = 2'b01; i_we = 2'b00; i_addr0 = 9'd127;
    for (int k = 1; k <= 5; k++) begin
      model_eval();
      n_cmp++; if (o_rvalid !== exp_rvalid) begin n_err++; $display("FAIL wr_rvalid T+%0d got=%0h want=%0h", k, o_rvalid, exp_rvalid); end
      if (k == 4) begin
        n_cmp++; if (o_rvalid !== 2'b01 || o_rdata !== 256'h1234) begin n_err++; $display("FAIL wr_rdata got=%0h/%0h want=1/1234", o_rvalid, o_rdata); end
      end
      model_commit();
      drive_idle();
    end
  endtask

  task automatic test_random();
    logic [1:0] pend;
    pend = 2'b00;
    for (int k = 0; k < 300 + 4; k++) begin
      if (k < 300) begin
        for (int r = 0; r < 2; r++) begin
          if (!pend[r]) begin
            i_req[r] = ($urandom_range(0, 3) != 0);
            i_we[r]  = ($urandom_range(0, 2) == 0);
            if (r == 0) begin i_addr0 = 9'($urandom_range(0, 7)); i_wdata0 = {8{$urandom}}; end
            else begin i_addr1 = 9'($urandom_range(0, 7)); i_wdata1 = {8{$urandom}}; end
          end
          if ($urandom_range(0, 9) < 3) i_lock[r] = ~i_lock[r];
        end
        i_cnt_clr = ($urandom_range(0, 31) == 0);
      end else drive_idle();
      model_eval();
      n_cmp++; if (o_gnt !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt cyc%0d got=%0h want=%0h", k, o_gnt, exp_gnt); end
      n_cmp++; if (o_rvalid !== exp_rvalid) begin n_err++; $display("FAIL rnd_rvalid cyc%0d got=%0h want=%0h", k, o_rvalid, exp_rvalid); end
      if (exp_rvalid != 2'b00) begin
        n_cmp++; if (o_rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata cyc%0d got=%0h want=%0h", k, o_rdata, exp_rdata); end
      end
      n_cmp++; if (o_lock_owner !== exp_owner) begin n_err++; $display("FAIL rnd_owner cyc%0d got=%0h want=%0h", k, o_lock_owner, exp_owner); end
      n_cmp++; if (o_conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL rnd_cnt cyc%0d got=%0d want=%0d", k, o_conflict_cnt, exp_cnt); end
      pend = i_req & ~exp_gnt;
      model_commit();
    end
  endtask

  task automatic test_reset_midflight();
    i_req = 2'b01; i_we = 2'b00; i_addr0 = 9'd3;
    model_eval();
    n_cmp++; if (o_gnt !== exp_gnt) begin n_err++; $display("FAIL rst_gnt got=%0h want=%0h", o_gnt, exp_gnt); end
    model_commit();
    i_addr0 = 9'd4;
    model_eval(); model_commit();
    drive_idle(); i_reset_n = 1'b0;
    model_eval(); model_commit();
    i_reset_n = 1'b1;
    model_eval();
    n_cmp++; if (o_rvalid !== 2'b00 || o_gnt !== 2'b00) begin n_err++; $display("FAIL rst_rvalid_gnt got=%0h/%0h want=0/0", o_rvalid, o_gnt); end
    n_cmp++; if ({o_bram_en, o_bram_we} !== 2'b00 || o_bram_addr !== '0 || o_bram_wdata !== '0) begin
      n_err++; $display("FAIL rst_cmd got en/we=%0h addr=%0h wdata=%0h want=0", {o_bram_en, o_bram_we}, o_bram_addr, o_bram_wdata); end
    n_cmp++; if (o_conflict_cnt !== 16'h0 || o_lock_owner !== 2'b00 || o_rdata !== '0) begin
      n_err++; $display("FAIL rst_misc got cnt=%0h owner=%0h rdata=%0h want=0", o_conflict_cnt, o_lock_owner, o_rdata); end
    model_commit();
    for (int k = 0; k < 4; k++) begin
      model_eval();
      n_cmp++; if (o_rvalid !== 2'b00) begin n_err++; $display("FAIL rst_stale_rvalid cyc%0d got=%0h want=0", k, o_rvalid); end
      model_commit();
    end
  endtask

  task automatic test_counter_saturation();
    i_req = 2'b11; i_we = 2'b11; i_addr0 = 9'd200; i_addr1 = 9'd201;
    i_wdata0 = 256'hAA; i_wdata1 = 256'hBB;
    for (int k = 0; k < 70000; k++) begin
      model_eval();
      if (exp_cnt == 16'hFFFF) break;
      model_commit();
    end
    n_cmp++; if (o_conflict_cnt !== 16'hFFFF || o_conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_reach got=%0h want=ffff", o_conflict_cnt); end
    model_commit();
    for (int k = 0; k < 3; k++) begin
      model_eval();
      n_cmp++; if (o_conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold cyc%0d got=%0h want=ffff", k, o_conflict_cnt); end
      model_commit();
    end
    i_cnt_clr = 1'b1;
    model_eval(); model_commit();
    i_cnt_clr = 1'b0;
    model_eval();
    n_cmp++; if (o_conflict_cnt !== 16'h0 || o_conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_clear got=%0h want=0", o_conflict_cnt); end
    model_commit();
    drive_idle();
  endtask

  initial begin
    m_last = 1; m_owner = -1; m_cnt = 0; cyc = 0;
    for (int i = 0; i < 512; i++) m_mem[i] = preload(i);
    test_reset();
    test_solo_read();
    test_tie_fairness();
    test_lock();
    test_write_read();
    test_random();
    test_reset_midflight();
    test_counter_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
